// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with start/busy/done handshake.
// The accepting edge captures the operands. Single-cycle ops retire on the
// following edge. Shifts by n >= 2 and MUL iterate in EXEC, one step per edge.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             flg_gr_o,
  output logic             flg_eq_o,
  output logic             flg_zero_o,
  output logic             flg_carry_o
);
  typedef enum logic {S_IDLE, S_EXEC} state_t;

  localparam logic [3:0] OP_AND = 4'd0,  OP_NAND = 4'd1, OP_OR  = 4'd2,  OP_NOR  = 4'd3,
                         OP_XOR = 4'd4,  OP_XNOR = 4'd5, OP_ADD = 4'd6,  OP_SUB  = 4'd7,
                         OP_ADC = 4'd8,  OP_SBB  = 4'd9, OP_CMP = 4'd10, OP_SHL  = 4'd11,
                         OP_SHR = 4'd12, OP_ASR  = 4'd13, OP_MUL = 4'd14;

  state_t             state_q, state_d;
  logic               pend_q, pend_d;   // single-cycle op waiting to retire
  logic               cin_q, cin_d;     // carry as it was at acceptance
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;   // shift accumulator (low half) / MUL {hi,lo}
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
  logic               gr_q, gr_d, eq_q, eq_d, zero_q, zero_d, carry_q, carry_d, done_q, done_d;

  logic [WIDTH-1:0]   b_op, res, res_hi;
  logic               cin, fin, wr_res;
  logic [WIDTH:0]     sum, sh1, shx, mstep;
  logic [SHW-1:0]     n_q, n_i;

  // One-bit shift; returns {shifted-out bit, shifted value}.
  function automatic logic [WIDTH:0] shift1(input logic [3:0] sop, input logic [WIDTH-1:0] v);
    case (sop)
      OP_SHL:  shift1 = {v, 1'b0};
      OP_SHR:  shift1 = {v[0], 1'b0, v[WIDTH-1:1]};
      default: shift1 = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign n_q = opb_q[SHW-1:0];
  assign n_i = operand_b_i[SHW-1:0];

  // Shared datapath: adder for the add/sub family, shifter, shift-add MUL step.
  always_comb begin
    b_op = (op_q == OP_SUB || op_q == OP_SBB || op_q == OP_CMP) ? ~opb_q : opb_q;
    case (op_q)
      OP_SUB, OP_CMP: cin = 1'b1;
      OP_ADC, OP_SBB: cin = cin_q;
      default:        cin = 1'b0;
    endcase
    sum   = {1'b0, opa_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    sh1   = shift1(op_q, opa_q);
    shx   = shift1(op_q, prod_q[WIDTH-1:0]);
    mstep = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opa_q : {WIDTH{1'b0}})};
  end

  // Control FSM: retire pending/iterating op, then accept a new request.
  always_comb begin
    state_d  = state_q;
    pend_d   = 1'b0;
    cin_d    = cin_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_d     = hi_q;
    gr_d     = gr_q;
    eq_d     = eq_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    res      = '0;
    res_hi   = '0;
    fin      = 1'b0;
    wr_res   = 1'b1;

    if (pend_q) begin
      fin = 1'b1;
      case (op_q)
        OP_AND:  res = opa_q & opb_q;
        OP_NAND: res = ~(opa_q & opb_q);
        OP_OR:   res = opa_q | opb_q;
        OP_NOR:  res = ~(opa_q | opb_q);
        OP_XOR:  res = opa_q ^ opb_q;
        OP_XNOR: res = ~(opa_q ^ opb_q);
        OP_ADD, OP_ADC, OP_SBB: begin
          res     = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        OP_SUB, OP_CMP: begin
          res     = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          gr_d    = sum[WIDTH] & (|sum[WIDTH-1:0]);
          eq_d    = sum[WIDTH] & ~(|sum[WIDTH-1:0]);
          wr_res  = (op_q != OP_CMP);
        end
        OP_SHL, OP_SHR, OP_ASR: begin
          if (n_q == '0) begin
            res     = opa_q;
            carry_d = 1'b0;
          end else begin
            res     = sh1[WIDTH-1:0];
            carry_d = sh1[WIDTH];
          end
        end
        default: res = opb_q;  // PASSB; MUL is never pending
      endcase
    end

    if (state_q == S_EXEC) begin
      if (op_q == OP_MUL) begin
        prod_d = {mstep, prod_q[WIDTH-1:1]};
        if (cnt_q == '0) begin
          fin     = 1'b1;
          res     = prod_d[WIDTH-1:0];
          res_hi  = prod_d[2*WIDTH-1:WIDTH];
          carry_d = |prod_d[2*WIDTH-1:WIDTH];
        end
      end else begin
        prod_d[WIDTH-1:0] = shx[WIDTH-1:0];
        if (cnt_q == '0) begin
          fin     = 1'b1;
          res     = shx[WIDTH-1:0];
          carry_d = shx[WIDTH];
        end
      end
      if (cnt_q == '0) state_d = S_IDLE;
      else             cnt_d   = cnt_q - SHW'(1);
    end

    if (fin) begin
      done_d = 1'b1;
      hi_d   = res_hi;
      zero_d = ~(|{res_hi, res});
      if (wr_res) result_d = res;
    end

    if (start_i && state_q == S_IDLE) begin
      op_d  = opcode_i;
      opa_d = operand_a_i;
      opb_d = operand_b_i;
      cin_d = carry_q;
      case (opcode_i)
        OP_MUL: begin
          prod_d  = {{WIDTH{1'b0}}, operand_b_i};
          cnt_d   = SHW'(WIDTH - 1);
          state_d = S_EXEC;
        end
        OP_SHL, OP_SHR, OP_ASR: begin
          if (n_i > SHW'(1)) begin
            prod_d  = {{WIDTH{1'b0}}, operand_a_i};
            cnt_d   = n_i - SHW'(1);
            state_d = S_EXEC;
          end else begin
            pend_d = 1'b1;
          end
        end
        default: pend_d = 1'b1;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      cin_q    <= 1'b0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      gr_q     <= 1'b0;
      eq_q     <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cin_q    <= cin_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      gr_q     <= gr_d;
      eq_q     <= eq_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign busy_o      = (state_q == S_EXEC);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_hi_o = hi_q;
  assign flg_gr_o    = gr_q;
  assign flg_eq_o    = eq_q;
  assign flg_zero_o  = zero_q;
  assign flg_carry_o = carry_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq;
  localparam int     W = 8;
  localparam longint M = (longint'(1) << W) - 1;
  localparam longint H = longint'(1) << (W - 1);

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy_o, done_o, flg_gr_o, flg_eq_o, flg_zero_o, flg_carry_o;
  logic [W-1:0] result_o, result_hi_o;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(op),
    .operand_a_i(a), .operand_b_i(b), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .result_hi_o(result_hi_o), .flg_gr_o(flg_gr_o),
    .flg_eq_o(flg_eq_o), .flg_zero_o(flg_zero_o), .flg_carry_o(flg_carry_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_res, m_hi;
  logic         m_gr, m_eq, m_zero, m_c;

  wire [2*W+3:0] act = {result_o, result_hi_o, flg_gr_o, flg_eq_o, flg_zero_o, flg_carry_o};

  function automatic logic [2*W+3:0] expv();
    return {m_res, m_hi, m_gr, m_eq, m_zero, m_c};
  endfunction

  task automatic model_reset();
    m_res = '0; m_hi = '0; m_gr = 0; m_eq = 0; m_zero = 0; m_c = 0;
  endtask

  // Applies one op to the model; returns expected latency in edges.
  task automatic model_op(input int o, input longint x, input longint y, output int lat);
    longint r, s, sx;
    int n;
    n = int'(y % W);
    lat = 1;
    m_hi = '0;
    r = 0;
    case (o)
      0: r = x & y;
      1: r = ~(x & y) & M;
      2: r = x | y;
      3: r = ~(x | y) & M;
      4: r = x ^ y;
      5: r = ~(x ^ y) & M;
      6, 8: begin s = x + y + ((o == 8) ? longint'(m_c) : 0); r = s & M; m_c = (s > M); end
      7, 10: begin r = (x - y) & M; m_c = (x >= y); m_gr = (x > y); m_eq = (x == y); end
      9: begin s = x + (M - y) + longint'(m_c); r = s & M; m_c = (s > M); end
      11, 12, 13: begin
        lat = (n == 0) ? 1 : n;
        if (o == 11) r = (x << n) & M;
        else if (o == 12) r = x >> n;
        else begin sx = (x >= H) ? x - (M + 1) : x; r = (sx >>> n) & M; end
        if (n == 0) m_c = 0;
        else if (o == 11) m_c = ((x >> (W - n)) & 1) != 0;
        else m_c = ((x >> (n - 1)) & 1) != 0;
      end
      14: begin s = x * y; r = s & M; m_hi = W'(s >> W); m_c = (m_hi != 0); lat = W; end
      default: r = y;
    endcase
    m_zero = (r == 0) && (m_hi == '0);
    if (o != 10) m_res = W'(r);
  endtask

  // Presents a request at a negedge; returns just after the accepting edge
  // with the inputs scrambled so the DUT must use its own copies.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  // Counts edges until done_o; lat = -1 on timeout. Optionally raises
  // start_i for one cycle after edge 'poke'.
  task automatic wait_done(output int lat, output logic bsy, input int poke);
    lat = 0; bsy = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      start = (poke != 0 && lat == poke);
      if (done_o) begin bsy = busy_o; break; end
      if (lat > 4 * W + 10) begin lat = -1; break; end
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({act, busy_o, done_o} !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", {act, busy_o, done_o}); end
    start = 1; op = 4'd6; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    checks++;
    if ({done_o, result_o} !== '0) begin errors++; $display("FAIL reset_hold got %h want 0", {done_o, result_o}); end
    start = 0;
    @(negedge clk); rst = 0;
    model_reset();
  endtask

  task automatic test_sub_cmp();
    int L, lat; logic bz;
    issue(4'd7, 8'h05, 8'h05); model_op(7, 5, 5, L);
    wait_done(lat, bz, 0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sub_latency got %0d want 1", lat); end
    checks++;
    if ({result_o, flg_gr_o, flg_eq_o, flg_zero_o, flg_carry_o} !== {8'h00, 4'b0111})
      begin errors++; $display("FAIL sub_flags got %h want %h", {result_o, flg_gr_o, flg_eq_o, flg_zero_o, flg_carry_o}, {8'h00, 4'b0111}); end
    issue(4'd15, 8'h00, 8'hA5); model_op(15, 0, 'hA5, L);
    wait_done(lat, bz, 0);
    checks++;
    if (result_o !== 8'hA5) begin errors++; $display("FAIL passb got %h want a5", result_o); end
    issue(4'd10, 8'h03, 8'h07); model_op(10, 3, 7, L);
    wait_done(lat, bz, 0);
    checks++;
    if ({lat == 1, result_o, flg_gr_o, flg_eq_o, flg_carry_o, flg_zero_o} !== {1'b1, 8'hA5, 4'b0000})
      begin errors++; $display("FAIL cmp got lat %0d %h want a5/0000", lat, {result_o, flg_gr_o, flg_eq_o, flg_carry_o, flg_zero_o}); end
  endtask

  task automatic test_carry_chain();
    int L, lat; logic bz;
    issue(4'd6, 8'hFF, 8'h01); model_op(6, 'hFF, 1, L);
    wait_done(lat, bz, 0);
    checks++;
    if ({result_o, flg_carry_o, flg_zero_o} !== {8'h00, 2'b11})
      begin errors++; $display("FAIL add_carry got %h want 003", {result_o, flg_carry_o, flg_zero_o}); end
    issue(4'd8, 8'h00, 8'h00); model_op(8, 0, 0, L);
    wait_done(lat, bz, 0);
    checks++;
    if ({result_o, flg_carry_o, flg_zero_o} !== {8'h01, 2'b00})
      begin errors++; $display("FAIL adc got %h want 004", {result_o, flg_carry_o, flg_zero_o}); end
  endtask

  task automatic test_shifts();
    int L, lat; logic bz;
    issue(4'd11, 8'h81, 8'h01); model_op(11, 'h81, 1, L);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL shl1_busy got %b want 0", busy_o); end
    wait_done(lat, bz, 0);
    checks++;
    if ({lat == 1, result_o, flg_carry_o} !== {1'b1, 8'h02, 1'b1})
      begin errors++; $display("FAIL shl1 got lat %0d res %h c %b want 1 02 1", lat, result_o, flg_carry_o); end
    issue(4'd12, 8'h5A, 8'h00); model_op(12, 'h5A, 0, L);
    wait_done(lat, bz, 0);
    checks++;
    if ({lat == 1, result_o, flg_carry_o} !== {1'b1, 8'h5A, 1'b0})
      begin errors++; $display("FAIL shr0 got lat %0d res %h c %b want 1 5a 0", lat, result_o, flg_carry_o); end
    issue(4'd13, 8'h80, 8'h03); model_op(13, 'h80, 3, L);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL asr_busy got %b want 1", busy_o); end
    wait_done(lat, bz, 0);
    checks++;
    if ({lat == 3, bz, result_o, flg_carry_o} !== {2'b10, 8'hF0, 1'b0})
      begin errors++; $display("FAIL asr3 got lat %0d busy %b res %h c %b want 3 0 f0 0", lat, bz, result_o, flg_carry_o); end
  endtask

  task automatic test_mul();
    int L, lat, nd; logic bz;
    issue(4'd14, 8'hFF, 8'hFF); model_op(14, 'hFF, 'hFF, L);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mul_busy got %b want 1", busy_o); end
    wait_done(lat, bz, 4);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, W); end
    checks++;
    if ({result_hi_o, result_o, flg_carry_o, bz} !== {8'hFE, 8'h01, 2'b10})
      begin errors++; $display("FAIL mul_product got %h%h c %b busy %b want fe01 1 0", result_hi_o, result_o, flg_carry_o, bz); end
    nd = 0;
    repeat (4) begin @(posedge clk); #1; if (done_o) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL mul_ignored_start got %0d extra done want 0", nd); end
  endtask

  task automatic test_reset_mid_mul();
    int L, lat, nd; logic bz;
    issue(4'd14, 8'hFF, 8'hFF);
    repeat (2) @(posedge clk); #1;
    rst = 1; #1;
    checks++;
    if ({act, busy_o, done_o} !== '0) begin errors++; $display("FAIL reset_mid_mul got %h want 0", {act, busy_o, done_o}); end
    @(posedge clk); @(negedge clk); rst = 0;
    model_reset();
    nd = 0;
    repeat (10) begin @(posedge clk); #1; if (done_o) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL reset_no_done got %0d want 0", nd); end
    issue(4'd6, 8'h01, 8'h02); model_op(6, 1, 2, L);
    wait_done(lat, bz, 0);
    checks++;
    if ({lat == 1, result_o} !== {1'b1, 8'h03}) begin errors++; $display("FAIL add_after_reset got lat %0d res %h want 1 03", lat, result_o); end
  endtask

  task automatic test_back_to_back();
    int L; logic seen_busy;
    @(negedge clk);
    start = 1; op = 4'd4; a = 8'hF0; b = 8'hFF;
    model_op(4, 'hF0, 'hFF, L);
    @(posedge clk); #1;
    seen_busy = busy_o;
    op = 4'd6; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    seen_busy |= busy_o;
    start = 0;
    checks++;
    if ({done_o, act} !== {1'b1, expv()}) begin errors++; $display("FAIL b2b_xor got %h want %h", {done_o, act}, {1'b1, expv()}); end
    model_op(6, 'h10, 'h20, L);
    @(posedge clk); #1;
    seen_busy |= busy_o;
    checks++;
    if ({done_o, act} !== {1'b1, expv()}) begin errors++; $display("FAIL b2b_add got %h want %h", {done_o, act}, {1'b1, expv()}); end
    checks++;
    if (result_o !== 8'h30) begin errors++; $display("FAIL b2b_add_result got %h want 30", result_o); end
    @(posedge clk); #1;
    checks++;
    if ({seen_busy, done_o} !== 2'b00) begin errors++; $display("FAIL b2b_busy_done got %b want 00", {seen_busy, done_o}); end
  endtask

  task automatic test_random();
    int L, lat; logic bz;
    logic [3:0] o; logic [W-1:0] x, y;
    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15)); x = W'($urandom); y = W'($urandom);
      issue(o, x, y);
      model_op(int'(o), longint'(x), longint'(y), L);
      checks++;
      if (busy_o !== (L > 1)) begin errors++; $display("FAIL rnd_busy op %0d got %b want %b", o, busy_o, L > 1); end
      wait_done(lat, bz, 0);
      checks++;
      if ({lat == L, bz} !== 2'b10) begin errors++; $display("FAIL rnd_latency op %0d got %0d busy %b want %0d", o, lat, bz, L); end
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL rnd_result op %0d a %h b %h got %h want %h", o, x, y, act, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_sub_cmp();
    test_carry_chain();
    test_shifts();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU, the next generation of the datapath's 8-bit combinational ALU. It executes single-cycle logic and arithmetic ops plus multi-cycle shifts and an iterative unsigned multiply under a start/busy/done handshake. Results and flags (greater, equal, zero, carry) are registered. It sits between the register file and the control FSM; the control FSM issues `start_i` and stalls on `busy_o`.

## Interface
- `WIDTH`, default 8: operand/result width; must be ≥ 4 and a power of 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request; accepted only while `busy_o`=0.
- `opcode_i`  in  4  operation; sampled with `start_i`.
- `operand_a_i`  in  WIDTH  operand A; sampled with `start_i`.
- `operand_b_i`  in  WIDTH  operand B or shift amount in `[SHW-1:0]`; sampled with `start_i`.
- `busy_o`  out  1  multi-cycle op in progress.
- `done_o`  out  1  one-cycle pulse; result and flags valid from this cycle on.
- `result_o`  out  WIDTH  result; holds until the next op completes.
- `result_hi_o`  out  WIDTH  upper half of the MUL product; 0 for all other ops.
- `flg_gr_o`  out  1  A > B unsigned; updated by SUB and CMP only.
- `flg_eq_o`  out  1  A == B; updated by SUB and CMP only.
- `flg_zero_o`  out  1  computed result == 0; updated by every op.
- `flg_carry_o`  out  1  carry / no-borrow / shifted-out bit / MUL overflow.

## Operation
- Opcodes 0–5 (single-cycle, carry unchanged): AND, NAND, OR, NOR, XOR, XNOR.
- Opcode 6, ADD: A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
- Opcode 7, SUB: A+~B+1; carry = 1 when there is no borrow (A ≥ B).
- Opcode 8, ADC: A+B+carry.
- Opcode 9, SBB: A+~B+carry.
- Opcode 10, CMP: same as SUB, but `result_o` is not written. Gr, eq, zero and carry are updated.
- Opcode 11, SHL: A shifted left by n=B[SHW-1:0], one bit per cycle. Carry = last bit shifted out; carry = 0 if n=0.
- Opcode 12, SHR: logical right shift, otherwise as SHL.
- Opcode 13, ASR: arithmetic right shift (sign bit replicated), otherwise as SHL.
- Opcode 14, MUL: unsigned shift-add, one bit of B per cycle. Product goes to {`result_hi_o`,`result_o`}; carry = (hi ≠ 0).
- Opcode 15, PASSB: result = B.
- SUB/CMP flags: gr = carry & (diff ≠ 0); eq = carry & (diff = 0).
- Flags not listed for an op keep their previous value.
- FSM states:
  - IDLE → (start_i & single-cycle op) → IDLE, with `done_o` pulsed.
  - IDLE → (start_i & shift with n≥2, or MUL) → EXEC.
  - EXEC counts down an iteration counter; at 0 → IDLE and pulse `done_o`.
  - A shift with n=1 completes like a single-cycle op.

## Timing
- Reset values: all outputs 0, FSM in IDLE, internal operand, accumulator and counter registers 0.
- Reset mid-operation aborts the op; no `done_o` is produced.
- Start accepted at edge k. `done_o`, `result_o` and flags update at edge k+L:
  - L=1 for ops 0–10 and 15.
  - L=max(n,1) for shifts.
  - L=WIDTH for MUL.
- `busy_o` = 1 from edge k to edge k+L when L > 1; it is 0 in the cycle `done_o` is 1.
- `start_i` while `busy_o`=1 is ignored; no queuing.
- `start_i` in the same cycle as `done_o` is accepted (back-to-back ops).
- Operand inputs may change freely after acceptance; internal copies are used.
- Arithmetic is modulo 2^WIDTH.
- ADC/SBB use the carry value registered before edge k.

## Test plan
- Reset during MUL: WIDTH=8, start MUL 0xFF×0xFF, assert `rst_i` at cycle 3 → all outputs 0 immediately, no `done_o`. Next ADD 1+2 → result 0x03 after 1 cycle.
- SUB/CMP flags: SUB 0x05−0x05 → result 0, eq=1, gr=0, zero=1, carry=1. CMP 0x03,0x07 → gr=0, eq=0, carry=0, `result_o` unchanged.
- Carry chain: ADD 0xFF+0x01 → result 0x00, carry=1, zero=1. Then ADC 0x00+0x00 → 0x01, carry=0.
- Shifts: SHL 0x81 by 1 → 0x02, carry=1, L=1. ASR 0x80 by 3 → 0xF0, carry=0, busy for 3 cycles. SHR by 0 → result = A, carry=0, L=1.
- MUL: 0xFF×0xFF → hi=0xFE, lo=0x01, carry=1, `done_o` exactly 8 cycles after start. A `start_i` pulse at cycle 4 is ignored.
- Back-to-back: XOR 0xF0^0xFF issued with `start_i` held high through `done_o` → next op accepted that cycle, result 0x0F, `busy_o` never asserted.
